// File: rtl/dragon_body.sv
// Dragon body: shift-register history of segment tiles behind the head, length
// management (grow / hurt / death) and registered collision flags.
// Optional macro DRAGON_BODY_DIR_EN adds per-segment direction storage.
module dragon_body #(
    parameter int         MAX_LEN   = 8,
    parameter int         INIT_LEN  = 3,
    parameter logic [7:0] SPAWN_LOC = 8'h88,
    parameter int         HURT_LOSS = 2
) (
    input  logic                       frame_clk,
    input  logic                       rst,
    input  logic                       move_en,
    input  logic [7:0]                 head_location,
    input  logic [1:0]                 head_direction,
    input  logic                       grow,
    input  logic                       hurt,
    input  logic [7:0]                 player_location,
    input  logic [$clog2(MAX_LEN)-1:0] seg_index,
    output logic [7:0]                 seg_location,
    output logic [1:0]                 seg_direction,
    output logic                       seg_active,
    output logic [3:0]                 body_length,
    output logic                       player_hit,
    output logic                       self_hit,
    output logic                       dead,
    output logic [1:0]                 body_state
);

    localparam logic [3:0] MAX_L  = 4'(MAX_LEN);
    localparam logic [3:0] INIT_L = 4'(INIT_LEN);
    localparam logic [1:0] LOSS_L = 2'(HURT_LOSS);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SHRINK = 2'd1,
        DEAD   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] len_q, len_d;
    logic [1:0] pend_q, pend_d;
    logic [1:0] loss_q, loss_d;
    logic       player_hit_q, player_hit_d;
    logic       self_hit_q, self_hit_d;
    logic [7:0] seg_q [MAX_LEN];
    logic       shift_en;

    // Storage beyond the active length keeps shifting so growth reveals the old tail.
    assign shift_en = move_en && (state_q != DEAD);

    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_q[i] <= SPAWN_LOC;
            end
        end else if (shift_en) begin
            seg_q[0] <= head_location;
            for (int i = 1; i < MAX_LEN; i++) begin
                seg_q[i] <= seg_q[i-1];
            end
        end
    end

`ifdef DRAGON_BODY_DIR_EN
    logic [1:0] dir_q [MAX_LEN];

    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                dir_q[i] <= 2'd0;
            end
        end else if (shift_en) begin
            dir_q[0] <= head_direction;
            for (int i = 1; i < MAX_LEN; i++) begin
                dir_q[i] <= dir_q[i-1];
            end
        end
    end

    assign seg_direction = dir_q[seg_index];
`else
    logic unused_head_direction;
    assign unused_head_direction = ^head_direction;
    assign seg_direction         = 2'b00;
`endif

    always_ff @(posedge frame_clk or posedge rst) begin
        if (rst) begin
            state_q      <= RUN;
            len_q        <= INIT_L;
            pend_q       <= 2'd0;
            loss_q       <= 2'd0;
            player_hit_q <= 1'b0;
            self_hit_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            pend_q       <= pend_d;
            loss_q       <= loss_d;
            player_hit_q <= player_hit_d;
            self_hit_q   <= self_hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        pend_d  = pend_q;
        loss_d  = loss_q;
        unique case (state_q)
            RUN: begin
                // Hurt wins over a same-frame grow and discards any queued growth.
                if (hurt) begin
                    state_d = SHRINK;
                    loss_d  = LOSS_L;
                    pend_d  = 2'd0;
                end else if (move_en && (pend_q != 2'd0)) begin
                    if (len_q < MAX_L) begin
                        len_d  = len_q + 4'd1;
                        pend_d = grow ? pend_q : pend_q - 2'd1;
                    end else begin
                        pend_d = 2'd0;
                    end
                end else if (grow && (pend_q != 2'd3)) begin
                    pend_d = pend_q + 2'd1;
                end
            end
            SHRINK: begin
                len_d  = (len_q != 4'd0) ? len_q - 4'd1 : 4'd0;
                loss_d = hurt ? LOSS_L : ((loss_q != 2'd0) ? loss_q - 2'd1 : 2'd0);
                if (len_d == 4'd0) begin
                    state_d = DEAD;
                end else if (loss_d == 2'd0) begin
                    state_d = RUN;
                end
            end
            DEAD: begin
                len_d  = 4'd0;
                pend_d = 2'd0;
                loss_d = 2'd0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Flags sample the pre-edge segments, so they lag the inputs by one frame.
    always_comb begin
        player_hit_d = 1'b0;
        self_hit_d   = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (4'(i) < len_q) begin
                if (seg_q[i] == player_location) player_hit_d = 1'b1;
                if (seg_q[i] == head_location)   self_hit_d   = 1'b1;
            end
        end
        if (state_d == DEAD) begin
            player_hit_d = 1'b0;
            self_hit_d   = 1'b0;
        end
    end

    assign seg_location = seg_q[seg_index];
    assign seg_active   = (4'(seg_index) < len_q);
    assign body_length  = len_q;
    assign player_hit   = player_hit_q;
    assign self_hit     = self_hit_q;
    assign dead         = (state_q == DEAD);
    assign body_state   = state_q;

endmodule

// File: tb/tb_dragon_body.sv
// Directed bench for dragon_body: a vector table for the main frame-by-frame
// behaviour plus hand sequences for growth saturation, hurt reload and reset.
module tb_dragon_body;

    logic       frame_clk;
    logic       rst;
    logic       move_en;
    logic [7:0] head_location;
    logic [1:0] head_direction;
    logic       grow;
    logic       hurt;
    logic [7:0] player_location;
    logic [2:0] seg_index;
    logic [7:0] seg_location;
    logic [1:0] seg_direction;
    logic       seg_active;
    logic [3:0] body_length;
    logic       player_hit;
    logic       self_hit;
    logic       dead;
    logic [1:0] body_state;

    int n_chk  = 0;
    int n_pass = 0;

    dragon_body dut (
        .frame_clk      (frame_clk),
        .rst            (rst),
        .move_en        (move_en),
        .head_location  (head_location),
        .head_direction (head_direction),
        .grow           (grow),
        .hurt           (hurt),
        .player_location(player_location),
        .seg_index      (seg_index),
        .seg_location   (seg_location),
        .seg_direction  (seg_direction),
        .seg_active     (seg_active),
        .body_length    (body_length),
        .player_hit     (player_hit),
        .self_hit       (self_hit),
        .dead           (dead),
        .body_state     (body_state)
    );

    // clock
    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    typedef struct {
        logic       mv;
        logic [7:0] head;
        logic [1:0] hdir;
        logic       gr;
        logic       hu;
        logic [7:0] pl;
        logic [2:0] idx;
        logic [7:0] e_loc;
        logic [1:0] e_dir;
        logic       e_act;
        logic [3:0] e_len;
        logic       e_ph;
        logic       e_sh;
        logic [1:0] e_st;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(
        input logic mv, input logic [7:0] head, input logic [1:0] hdir,
        input logic gr, input logic hu, input logic [7:0] pl, input logic [2:0] idx,
        input logic [7:0] e_loc, input logic [1:0] e_dir, input logic e_act,
        input logic [3:0] e_len, input logic e_ph, input logic e_sh, input logic [1:0] e_st);
        vec_t v;
        v.mv = mv; v.head = head; v.hdir = hdir; v.gr = gr; v.hu = hu; v.pl = pl;
        v.idx = idx; v.e_loc = e_loc; v.e_dir = e_dir; v.e_act = e_act;
        v.e_len = e_len; v.e_ph = e_ph; v.e_sh = e_sh; v.e_st = e_st;
        return v;
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver: inputs change on the falling edge, outputs sampled 1ns after the rising edge
    task automatic step(input logic mv, input logic [7:0] head, input logic gr, input logic hu);
        @(negedge frame_clk);
        move_en         = mv;
        head_location   = head;
        head_direction  = 2'd0;
        grow            = gr;
        hurt            = hu;
        player_location = 8'h00;
        seg_index       = 3'd0;
        @(posedge frame_clk);
        #1;
    endtask

    task automatic async_reset_check(input string tag);
        @(negedge frame_clk);
        move_en = 1'b0; grow = 1'b0; hurt = 1'b0; seg_index = 3'd0;
        rst = 1'b1;
        #1;
        chk({tag, " state"}, 8'(body_state), 8'h00);
        chk({tag, " len"},   8'(body_length), 8'h03);
        chk({tag, " dead"},  8'(dead), 8'h00);
        chk({tag, " seg0"},  seg_location, 8'h88);
        @(negedge frame_clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [1:0] exp_dir;

        //               mv   head   hdir  gr   hu   pl     idx    loc    dir   act  len   ph   sh   st
        vecs[0]  = mk(1'b1, 8'h45, 2'd1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h45, 2'd1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0);
        vecs[1]  = mk(1'b1, 8'h55, 2'd2, 1'b0, 1'b0, 8'h00, 3'd1, 8'h45, 2'd1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0);
        vecs[2]  = mk(1'b1, 8'h65, 2'd3, 1'b0, 1'b0, 8'h00, 3'd2, 8'h45, 2'd1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0);
        vecs[3]  = mk(1'b0, 8'h75, 2'd0, 1'b0, 1'b0, 8'h00, 3'd3, 8'h88, 2'd0, 1'b0, 4'd3, 1'b0, 1'b0, 2'd0);
        vecs[4]  = mk(1'b0, 8'h75, 2'd0, 1'b1, 1'b0, 8'h00, 3'd0, 8'h65, 2'd3, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0);
        vecs[5]  = mk(1'b1, 8'h75, 2'd0, 1'b0, 1'b0, 8'h00, 3'd3, 8'h45, 2'd1, 1'b1, 4'd4, 1'b0, 1'b0, 2'd0);
        vecs[6]  = mk(1'b1, 8'h76, 2'd1, 1'b0, 1'b0, 8'h00, 3'd3, 8'h55, 2'd2, 1'b1, 4'd4, 1'b0, 1'b0, 2'd0);
        vecs[7]  = mk(1'b0, 8'h55, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h75, 2'd0, 1'b1, 4'd4, 1'b0, 1'b1, 2'd0);
        vecs[8]  = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h75, 3'd1, 8'h75, 2'd0, 1'b1, 4'd4, 1'b1, 1'b0, 2'd0);
        vecs[9]  = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h45, 3'd4, 8'h45, 2'd1, 1'b0, 4'd4, 1'b0, 1'b0, 2'd0);
        vecs[10] = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h88, 3'd5, 8'h88, 2'd0, 1'b0, 4'd4, 1'b0, 1'b0, 2'd0);
        vecs[11] = mk(1'b0, 8'h99, 2'd0, 1'b1, 1'b1, 8'h00, 3'd0, 8'h76, 2'd1, 1'b1, 4'd4, 1'b0, 1'b0, 2'd1);
        vecs[12] = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h76, 2'd1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd1);
        vecs[13] = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h76, 2'd1, 1'b1, 4'd2, 1'b0, 1'b0, 2'd0);
        vecs[14] = mk(1'b1, 8'h9A, 2'd2, 1'b0, 1'b0, 8'h00, 3'd0, 8'h9A, 2'd2, 1'b1, 4'd2, 1'b0, 1'b0, 2'd0);
        vecs[15] = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h76, 2'd1, 1'b1, 4'd2, 1'b0, 1'b0, 2'd1);
        vecs[16] = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h00, 3'd1, 8'h76, 2'd1, 1'b0, 4'd1, 1'b0, 1'b0, 2'd1);
        vecs[17] = mk(1'b0, 8'h99, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0, 8'h9A, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2);
        vecs[18] = mk(1'b1, 8'hAA, 2'd3, 1'b0, 1'b0, 8'h00, 3'd0, 8'h9A, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2);
        vecs[19] = mk(1'b1, 8'h9A, 2'd3, 1'b1, 1'b1, 8'h9A, 3'd0, 8'h9A, 2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2);

        // reset
        rst = 1'b1; move_en = 1'b0; head_location = 8'h00; head_direction = 2'd0;
        grow = 1'b0; hurt = 1'b0; player_location = 8'h00; seg_index = 3'd0;
        repeat (2) @(negedge frame_clk);
        chk("reset len",   8'(body_length), 8'h03);
        chk("reset state", 8'(body_state), 8'h00);
        chk("reset dead",  8'(dead), 8'h00);
        chk("reset phit",  8'(player_hit), 8'h00);
        chk("reset shit",  8'(self_hit), 8'h00);
        chk("reset seg0",  seg_location, 8'h88);
        chk("reset dir0",  8'(seg_direction), 8'h00);
        chk("reset act0",  8'(seg_active), 8'h01);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge frame_clk);
            move_en         = vecs[i].mv;
            head_location   = vecs[i].head;
            head_direction  = vecs[i].hdir;
            grow            = vecs[i].gr;
            hurt            = vecs[i].hu;
            player_location = vecs[i].pl;
            seg_index       = vecs[i].idx;
            @(posedge frame_clk);
            #1;
`ifdef DRAGON_BODY_DIR_EN
            exp_dir = vecs[i].e_dir;
`else
            exp_dir = 2'b00;
`endif
            chk($sformatf("v%0d loc", i),   seg_location, vecs[i].e_loc);
            chk($sformatf("v%0d dir", i),   8'(seg_direction), 8'(exp_dir));
            chk($sformatf("v%0d act", i),   8'(seg_active), 8'(vecs[i].e_act));
            chk($sformatf("v%0d len", i),   8'(body_length), 8'(vecs[i].e_len));
            chk($sformatf("v%0d phit", i),  8'(player_hit), 8'(vecs[i].e_ph));
            chk($sformatf("v%0d shit", i),  8'(self_hit), 8'(vecs[i].e_sh));
            chk($sformatf("v%0d state", i), 8'(body_state), 8'(vecs[i].e_st));
            chk($sformatf("v%0d dead", i),  8'(dead), 8'(vecs[i].e_st == 2'd2));
        end

        // reset out of DEAD
        async_reset_check("rst_dead");

        // pending_grow saturates at 3: four grows then four moves give +3
        repeat (4) step(1'b0, 8'h11, 1'b1, 1'b0);
        repeat (4) step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("sat len", 8'(body_length), 8'h06);
        chk("sat state", 8'(body_state), 8'h00);

        // grow with a consuming move: length +1, pending unchanged
        step(1'b0, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b1, 1'b0);
        chk("gm len", 8'(body_length), 8'h07);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("gm2 len", 8'(body_length), 8'h08);
        step(1'b0, 8'h11, 1'b1, 1'b0);
        step(1'b1, 8'h11, 1'b0, 1'b0);
        chk("max len", 8'(body_length), 8'h08);

        // hurt reload during SHRINK extends the shrink
        step(1'b0, 8'h11, 1'b0, 1'b1);
        chk("hr0 state", 8'(body_state), 8'h01);
        chk("hr0 len",   8'(body_length), 8'h08);
        step(1'b0, 8'h11, 1'b0, 1'b1);
        chk("hr1 len",   8'(body_length), 8'h07);
        step(1'b0, 8'h11, 1'b0, 1'b0);
        chk("hr2 state", 8'(body_state), 8'h01);
        chk("hr2 len",   8'(body_length), 8'h06);
        step(1'b0, 8'h11, 1'b0, 1'b0);
        chk("hr3 state", 8'(body_state), 8'h00);
        chk("hr3 len",   8'(body_length), 8'h05);

        // reset mid-SHRINK
        step(1'b0, 8'h11, 1'b0, 1'b1);
        step(1'b0, 8'h11, 1'b0, 1'b0);
        chk("ms state", 8'(body_state), 8'h01);
        chk("ms len",   8'(body_length), 8'h04);
        async_reset_check("rst_shrink");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
